// File: rtl/ccg_bist_harness.sv
// rtl/ccg_bist_harness.sv - LFSR stimulus / MISR compaction self-test harness for combinational cores
module ccg_bist_harness #(
    parameter int unsigned N_IN        = 27,
    parameter int unsigned N_OUT       = 27,
    parameter int unsigned LFSR_W      = 32,
    parameter int unsigned MISR_W      = 32,
    parameter logic [31:0] POLY        = 32'h00400007,
    parameter logic [31:0] SEED        = 32'h00000001,
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned DUT_LAT     = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MISR_W-1:0] golden,
    output logic [N_IN-1:0]   dut_x,
    input  logic [N_OUT-1:0]  dut_f,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic              pass
);

    localparam logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(POLY);
    localparam logic [MISR_W-1:0] MISR_POLY = MISR_W'(POLY);
    localparam logic [LFSR_W-1:0] SEED_T    = LFSR_W'(SEED);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED_T == '0) ? LFSR_W'(1) : SEED_T;
    localparam logic [CNT_W-1:0]  LAST_VEC  = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0]  LAST_DRN  = CNT_W'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);
    localparam int unsigned       PW        = (DUT_LAT > 0) ? DUT_LAT : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_adv;
    logic [MISR_W-1:0] misr;
    logic [MISR_W-1:0] misr_next;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     vpipe;
    logic              load;
    logic              capture;
    logic              enter_done;

    function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [MISR_W-1:0] misr_shift(input logic [MISR_W-1:0] s);
        return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST_VEC) begin
                    state_next = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (cnt == LAST_DRN) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // With no core latency the response belongs to the vector on dut_x right now;
    // otherwise the delayed valid bit marks which cycles carry a real response.
    always_comb begin
        capture = 1'b0;
        if (DUT_LAT == 0) begin
            capture = (state == S_RUN);
        end else begin
            capture = vpipe[PW-1];
        end
        misr_next  = capture ? (misr_shift(misr) ^ MISR_W'(dut_f)) : misr;
        lfsr_adv   = lfsr_shift(lfsr);
        enter_done = (state_next == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= '0;
            misr      <= '0;
            cnt       <= '0;
            vpipe     <= '0;
            dut_x     <= '0;
            signature <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vpipe <= (vpipe << 1) | PW'(state == S_RUN);
            if (load) begin
                lfsr  <= SEED_EFF;
                dut_x <= SEED_EFF[N_IN-1:0];
                misr  <= '0;
                cnt   <= '0;
                vpipe <= '0;
                pass  <= 1'b0;
            end else begin
                misr <= misr_next;
                case (state)
                    S_RUN: begin
                        lfsr <= lfsr_adv;
                        if (cnt == LAST_VEC) begin
                            dut_x <= '0;
                            cnt   <= '0;
                        end else begin
                            dut_x <= lfsr_adv[N_IN-1:0];
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    S_DRAIN: cnt <= cnt + 1'b1;
                    default: ;
                endcase
                if (enter_done) begin
                    signature <= misr_next;
                    pass      <= (misr_next == golden);
                end
            end
            busy <= (state_next == S_RUN) || (state_next == S_DRAIN);
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_ccg_bist_harness.sv
// tb/tb_ccg_bist_harness.sv - scoreboard bench for ccg_bist_harness across seed/latency variants
module tb_ccg_bist_harness;

    localparam int NI     = 4;
    localparam int K_VEC  = 0;
    localparam int K_DONE = 1;
    localparam int K_IDLE = 2;

    typedef struct {
        int         cyc;
        int         kind;
        int         inst;
        logic [3:0] x;
        logic [3:0] sig;
        bit         busy;
        bit         done;
        bit         pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       st     [NI];
    logic [3:0] gold   [NI];
    logic [3:0] dx     [NI];
    logic [3:0] df     [NI];
    logic       busy_v [NI];
    logic       done_v [NI];
    logic [3:0] sig_v  [NI];
    logic       pass_v [NI];
    int         mode   [NI];
    logic [3:0] mask   [NI];
    logic [3:0] p2a, p2b, p3;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nv_of(int i);
        return (i == 3) ? 11 : 3;
    endfunction
    function automatic int lat_of(int i);
        return (i == 2) ? 2 : ((i == 3) ? 1 : 0);
    endfunction
    function automatic int seed_of(int i);
        return (i == 1) ? 0 : ((i == 3) ? 5 : 1);
    endfunction

    // Multiply by x modulo x^4 + x + 1.
    function automatic logic [3:0] gf_mulx(logic [3:0] s);
        int w;
        w = int'(s) * 2;
        if (w >= 16) w = (w - 16) ^ 3;
        return 4'(w);
    endfunction

    function automatic logic [3:0] core_fn(int m, logic [3:0] k, logic [3:0] x);
        int w;
        case (m)
            0:       return x;
            1:       return 4'h1;
            2:       return 4'h0;
            3:       return x ^ k;
            default: begin
                w = ((int'(x) * 2) % 16) + int'(x) / 8 + int'(k);
                return 4'(w % 16);
            end
        endcase
    endfunction

    assign df[0] = core_fn(mode[0], mask[0], dx[0]);
    assign df[1] = core_fn(mode[1], mask[1], dx[1]);
    assign df[2] = p2b;
    assign df[3] = p3;

    always @(posedge clk) begin
        p2a <= core_fn(mode[2], mask[2], dx[2]);
        p2b <= p2a;
        p3  <= core_fn(mode[3], mask[3], dx[3]);
    end

    ccg_bist_harness #(.N_IN(4), .N_OUT(4), .LFSR_W(4), .MISR_W(4), .POLY(32'h3), .SEED(32'h1),
                       .NUM_VECTORS(3), .DUT_LAT(0), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .start(st[0]), .golden(gold[0]), .dut_x(dx[0]), .dut_f(df[0]),
        .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]), .pass(pass_v[0]));
    ccg_bist_harness #(.N_IN(4), .N_OUT(4), .LFSR_W(4), .MISR_W(4), .POLY(32'h3), .SEED(32'h0),
                       .NUM_VECTORS(3), .DUT_LAT(0), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .start(st[1]), .golden(gold[1]), .dut_x(dx[1]), .dut_f(df[1]),
        .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]), .pass(pass_v[1]));
    ccg_bist_harness #(.N_IN(4), .N_OUT(4), .LFSR_W(4), .MISR_W(4), .POLY(32'h3), .SEED(32'h1),
                       .NUM_VECTORS(3), .DUT_LAT(2), .CNT_W(8)) u_d2 (
        .clk(clk), .rst(rst), .start(st[2]), .golden(gold[2]), .dut_x(dx[2]), .dut_f(df[2]),
        .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]), .pass(pass_v[2]));
    ccg_bist_harness #(.N_IN(4), .N_OUT(4), .LFSR_W(4), .MISR_W(4), .POLY(32'h3), .SEED(32'h5),
                       .NUM_VECTORS(11), .DUT_LAT(1), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .start(st[3]), .golden(gold[3]), .dut_x(dx[3]), .dut_f(df[3]),
        .busy(busy_v[3]), .done(done_v[3]), .signature(sig_v[3]), .pass(pass_v[3]));

    task automatic chk(string nm, int i, int act, int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_VEC: begin
                    chk("dut_x", e.inst, int'(dx[e.inst]), int'(e.x));
                    chk("busy", e.inst, int'(busy_v[e.inst]), int'(e.busy));
                    chk("done", e.inst, int'(done_v[e.inst]), int'(e.done));
                end
                K_DONE: begin
                    chk("done_at_end", e.inst, int'(done_v[e.inst]), 1);
                    chk("busy_at_end", e.inst, int'(busy_v[e.inst]), 0);
                    chk("signature", e.inst, int'(sig_v[e.inst]), int'(e.sig));
                    chk("pass", e.inst, int'(pass_v[e.inst]), int'(e.pass));
                end
                default: begin
                    chk("idle_dut_x", e.inst, int'(dx[e.inst]), 0);
                    chk("idle_busy", e.inst, int'(busy_v[e.inst]), 0);
                    chk("idle_done", e.inst, int'(done_v[e.inst]), 0);
                    chk("idle_pass", e.inst, int'(pass_v[e.inst]), 0);
                    chk("idle_signature", e.inst, int'(sig_v[e.inst]), 0);
                end
            endcase
        end
    end

    function automatic exp_t mk(int c, int kind, int i, logic [3:0] x, logic [3:0] sig,
                                bit b, bit d, bit p);
        exp_t r;
        r.cyc = c; r.kind = kind; r.inst = i; r.x = x; r.sig = sig;
        r.busy = b; r.done = d; r.pass = p;
        return r;
    endfunction

    // Model: vector k is seed * x^k in GF(16); signature folds core(vector k) in order.
    task automatic do_run(int i, int m, logic [3:0] k, logic [3:0] gx, int pulse_at);
        logic [3:0] v;
        logic [3:0] s;
        int         t;
        int         nv;
        int         lat;
        nv  = nv_of(i);
        lat = lat_of(i);
        @(posedge clk); #1;
        t       = cyc;
        mode[i] = m;
        mask[i] = k;
        v = (seed_of(i) == 0) ? 4'h1 : 4'(seed_of(i));
        s = 4'h0;
        for (int n = 0; n < nv; n++) begin
            sb.push_back(mk(t + 1 + n, K_VEC, i, v, 4'h0, 1'b1, 1'b0, 1'b0));
            s = gf_mulx(s) ^ core_fn(m, k, v);
            v = gf_mulx(v);
        end
        sb.push_back(mk(t + 1 + nv, K_VEC, i, 4'h0, 4'h0, lat > 0, lat == 0, 1'b0));
        sb.push_back(mk(t + 1 + nv + lat, K_DONE, i, 4'h0, s, 1'b0, 1'b1, gx == 4'h0));
        gold[i] = s ^ gx;
        st[i]   = 1'b1;
        @(posedge clk); #1;
        st[i] = 1'b0;
        while (cyc < t + 1 + nv + lat) begin
            if (cyc == t + pulse_at) st[i] = 1'b1;
            @(posedge clk); #1;
            st[i] = 1'b0;
        end
    endtask

    task automatic reset_mid_run();
        int t;
        @(posedge clk); #1;
        t       = cyc;
        mode[0] = 1;
        sb.push_back(mk(t + 1, K_VEC, 0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0));
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.push_back(mk(t + 3, K_IDLE, 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0; gold[i] = 4'h0; mode[i] = 2; mask[i] = 4'h0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) sb.push_back(mk(cyc, K_IDLE, i, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        do_run(0, 0, 4'h0, 4'h0, 0);
        do_run(0, 1, 4'h0, 4'h0, 0);
        do_run(0, 1, 4'h0, 4'h1, 0);
        do_run(1, 2, 4'h0, 4'h0, 0);
        do_run(2, 1, 4'h0, 4'h0, 0);
        reset_mid_run();
        do_run(0, 1, 4'h0, 4'h0, 0);
        do_run(3, 3, 4'h5, 4'h0, 4);
        do_run(3, 3, 4'h5, 4'h0, 0);
        do_run(2, 0, 4'h0, 4'h0, 4);

        for (int r = 0; r < 40; r++) begin
            int         i;
            int         m;
            int         pa;
            logic [3:0] k;
            logic [3:0] gx;
            i  = $urandom_range(0, NI - 1);
            m  = $urandom_range(0, 4);
            k  = 4'($urandom);
            gx = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            pa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nv_of(i) + lat_of(i)) : 0;
            do_run(i, m, k, gx, pa);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 0, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
